// File: rtl/tx_fifo_pkg.sv
// Shared sizing for the TX FIFO controller and its register file.
package tx_fifo_pkg;
  localparam int TX_FIFO_DEPTH = 6;
  localparam int TX_WORDS      = 4;
  localparam int PTR_W         = 3;
  localparam int SIDE_W        = 2;
  localparam int CNT_W         = 3;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [SIDE_W-1:0] side_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/tx_fifo_ctrl_if.sv
// Request/status bundle between the TX FIFO controller and its producer/consumer.
interface tx_fifo_ctrl_if;
  import tx_fifo_pkg::*;

  logic  flush;
  logic  wr_req;
  logic  rd_req;
  logic  WE;
  ptr_t  tail_ptr;
  ptr_t  head_ptr;
  side_t head_side;
  cnt_t  count;
  logic  full;
  logic  empty;
  logic  overflow_err;
  logic  underflow_err;

  modport master (
    output flush, wr_req, rd_req,
    input  WE, tail_ptr, head_ptr, head_side, count, full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  flush, wr_req, rd_req,
    output WE, tail_ptr, head_ptr, head_side, count, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_fifo_ctrl_mod_counter.sv
// Modulo-MOD pointer: increments on inc, wraps MOD-1 to 0, clr/rst force 0.
module mod_counter #(
  parameter int MOD = 6,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == W'(MOD - 1)) ? '0 : q + 1'b1;
    end
  end
endmodule

// File: rtl/tx_fifo_ctrl.sv
// TX FIFO pointer/occupancy controller: block-wide pushes, 32-bit word pops.
module tx_fifo_ctrl
  import tx_fifo_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int WORDS = TX_WORDS
) (
  input logic           clk,
  input logic           rst,
  tx_fifo_ctrl_if.slave bus
);
  logic  push;
  logic  pop;
  logic  last;
  side_t side_q;
  cnt_t  count_q;
  logic  ovf_q;
  logic  unf_q;

  // Full is checked before any same-cycle pop, so a full FIFO never accepts a push.
  assign push = bus.wr_req & ~bus.full & ~bus.flush & ~rst;
  assign pop  = bus.rd_req & ~bus.empty & ~bus.flush & ~rst;
  assign last = pop & (side_q == side_t'(WORDS - 1));

  assign bus.WE            = push;
  assign bus.head_side     = side_q;
  assign bus.count         = count_q;
  assign bus.full          = ~rst & (count_q == cnt_t'(DEPTH));
  assign bus.empty         = rst | (count_q == '0);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

  mod_counter #(.MOD(DEPTH), .W(PTR_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (push),
    .q   (bus.tail_ptr)
  );

  mod_counter #(.MOD(DEPTH), .W(PTR_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .inc (last),
    .q   (bus.head_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      side_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q <= bus.wr_req & bus.full;
      unf_q <= bus.rd_req & bus.empty;
      if (bus.flush) begin
        side_q  <= '0;
        count_q <= '0;
      end else begin
        if (pop) begin
          side_q <= last ? '0 : side_q + 1'b1;
        end
        if (push && !last) begin
          count_q <= count_q + 1'b1;
        end else if (last && !push) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Directed scoreboard bench for tx_fifo_ctrl (DEPTH=6, WORDS=4).
module tb_tx_fifo_ctrl;
  typedef struct {
    bit we;
    int tail;
    int head;
    int side;
    int cnt;
    bit ovf;
    bit unf;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  tx_fifo_ctrl_if bus ();

  tx_fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // WE is checked with inputs settled before the edge; state just after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("WE", int'(bus.WE), int'(e.we));
        @(posedge clk);
        #1;
        chk("tail_ptr", int'(bus.tail_ptr), e.tail);
        chk("head_ptr", int'(bus.head_ptr), e.head);
        chk("head_side", int'(bus.head_side), e.side);
        chk("count", int'(bus.count), e.cnt);
        chk("full", int'(bus.full), (e.cnt == 6) ? 1 : 0);
        chk("empty", int'(bus.empty), (e.cnt == 0) ? 1 : 0);
        chk("overflow_err", int'(bus.overflow_err), int'(e.ovf));
        chk("underflow_err", int'(bus.underflow_err), int'(e.unf));
      end
    end
  end

  task automatic cyc(input bit wr, input bit rd, input bit fl, input bit rs,
                     input bit we, input int t, input int h, input int s, input int c,
                     input bit o, input bit u);
    exp_t e;
    @(negedge clk);
    bus.wr_req = wr;
    bus.rd_req = rd;
    bus.flush  = fl;
    rst        = rs;
    e.we = we; e.tail = t; e.head = h; e.side = s; e.cnt = c; e.ovf = o; e.unf = u;
    exp_q.push_back(e);
  endtask

  initial begin : driver
    clk = 1'b0;
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.flush  = 1'b0;
    n_pass = 0;
    n_total = 0;

    // reset, with a push request that must be masked
    cyc(1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    // one push, then four word pops
    cyc(1, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 0, 2, 1, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 0, 3, 1, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0);
    // pop while empty
    cyc(0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
    // flush beats a push
    cyc(1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    // fill to six, then overflow
    for (int i = 1; i <= 6; i++) cyc(1, 0, 0, 0,  1, i % 6, 0, 0, i, 0, 0);
    cyc(1, 0, 0, 0,  0, 0, 0, 0, 6, 1, 0);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 6, 0, 0);
    // full, push with last-word pop: push rejected, pop performed
    cyc(0, 1, 0, 0,  0, 0, 0, 1, 6, 0, 0);
    cyc(0, 1, 0, 0,  0, 0, 0, 2, 6, 0, 0);
    cyc(0, 1, 0, 0,  0, 0, 0, 3, 6, 0, 0);
    cyc(1, 1, 0, 0,  0, 0, 1, 0, 5, 1, 0);
    cyc(1, 0, 0, 0,  1, 1, 1, 0, 6, 0, 0);
    // drain four blocks
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        cyc(0, 1, 0, 0,  0, 1, (w == 3) ? 2 + b : 1 + b, (w + 1) % 4,
            (w == 3) ? 5 - b : 6 - b, 0, 0);
      end
    end
    // count=2, push with last-word pop: count holds, both pointers move, head wraps
    cyc(0, 1, 0, 0,  0, 1, 5, 1, 2, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 5, 2, 2, 0, 0);
    cyc(0, 1, 0, 0,  0, 1, 5, 3, 2, 0, 0);
    cyc(1, 1, 0, 0,  1, 2, 0, 0, 2, 0, 0);
    // mid-stream flush at head_side=2, count=3
    cyc(1, 0, 0, 0,  1, 3, 0, 0, 3, 0, 0);
    cyc(0, 1, 0, 0,  0, 3, 0, 1, 3, 0, 0);
    cyc(0, 1, 0, 0,  0, 3, 0, 2, 3, 0, 0);
    cyc(1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    // mid-stream reset at head_side=2, count=3
    cyc(1, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0,  1, 2, 0, 0, 2, 0, 0);
    cyc(1, 0, 0, 0,  1, 3, 0, 0, 3, 0, 0);
    cyc(0, 1, 0, 0,  0, 3, 0, 1, 3, 0, 0);
    cyc(0, 1, 0, 0,  0, 3, 0, 2, 3, 0, 0);
    cyc(1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
